// File: rtl/axis_upsize_if.sv
// AXI-Stream style handshake bundle shared by the narrow input and wide output sides.
interface axis_upsize_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned KEEP_W = 1
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;

  // Source side of a stream.
  modport master (
    output valid,
    output data,
    output keep,
    output last,
    input  ready
  );

  // Sink side of a stream.
  modport slave (
    input  valid,
    input  data,
    input  keep,
    input  last,
    output ready
  );
endinterface

// File: rtl/axis_upsize.sv
// Stream width upsizer: packs R narrow input beats into one wide output beat.
// A partial group (input last arrives early) is emitted with zeroed unfilled
// slots and the matching keep bits clear. One output register stage; the input
// is back-pressured only while a held output beat is not being taken.
module axis_upsize #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned S_BUS_W = 8,
  parameter int unsigned M_BUS_W = 32
) (
  input  logic           clk,
  input  logic           rstn,
  axis_upsize_if.slave   s,
  axis_upsize_if.master  m
);

  localparam int unsigned R     = M_BUS_W / S_BUS_W;
  localparam int unsigned CNT_W = $clog2(R);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(R - 1);

  // Elaboration-time guard on the width relationships.
  if ((S_BUS_W % WORD_W) != 0 || (M_BUS_W % S_BUS_W) != 0 || R < 2) begin : g_bad_param
    $error("axis_upsize: illegal WORD_W/S_BUS_W/M_BUS_W combination");
  end

  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [M_BUS_W-1:0] coll_q,   coll_d;
  logic [M_BUS_W-1:0] m_data_q, m_data_d;
  logic [R-1:0]       m_keep_q, m_keep_d;
  logic               m_last_q, m_last_d;
  logic               m_valid_q, m_valid_d;

  logic               s_ready_c;
  logic               s_hs_c;
  logic               m_hs_c;
  logic               complete_c;
  logic [M_BUS_W-1:0] merged_c;

  // Input may proceed whenever the output register is empty or draining.
  assign s_ready_c = !m_valid_q || m.ready;
  assign s.ready   = s_ready_c;

  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign m.keep  = m_keep_q;
  assign m.last  = m_last_q;

  // Next-state for collect buffer, slot counter and output register.
  always_comb begin
    cnt_d     = cnt_q;
    coll_d    = coll_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;

    s_hs_c     = s.valid && s_ready_c;
    m_hs_c     = m_valid_q && m.ready;
    complete_c = s_hs_c && ((cnt_q == CNT_MAX) || s.last);

    // Collect buffer with the current beat dropped into slot cnt.
    merged_c = coll_q;
    for (int unsigned i = 0; i < R; i++) begin
      if (CNT_W'(i) == cnt_q) begin
        merged_c[i*S_BUS_W +: S_BUS_W] = s.data;
      end
    end

    if (m_hs_c) begin
      m_valid_d = 1'b0;
    end

    if (s_hs_c) begin
      if (complete_c) begin
        m_data_d  = merged_c;
        m_last_d  = s.last;
        m_valid_d = 1'b1;
        for (int unsigned i = 0; i < R; i++) begin
          m_keep_d[i] = (CNT_W'(i) <= cnt_q);
        end
        coll_d = '0;
        cnt_d  = '0;
      end else begin
        coll_d = merged_c;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards any partial group and held output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      coll_q    <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      coll_q    <= coll_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_axis_upsize.sv
// Directed and random checks for axis_upsize with 8-bit input, 32-bit output.
module tb_axis_upsize;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  axis_upsize_if #(.DATA_W(8),  .KEEP_W(1)) s_if ();
  axis_upsize_if #(.DATA_W(32), .KEEP_W(4)) m_if ();

  axis_upsize dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (s_if),
    .m    (m_if)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] acc_data;
  logic [3:0]  acc_keep;
  int          acc_slot;
  int          errors;
  int          checks;
  int          n_in;
  int          n_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc_data = '0;
    acc_keep = '0;
    acc_slot = 0;
  endtask

  // Called between edges: predicts handshakes at the coming rising edge.
  task automatic observe();
    beat_t b;
    if (rstn) begin
      if (m_if.valid && m_if.ready) begin
        n_out++;
        check("m_data_known", 32'($isunknown(m_if.data)), 32'(0));
        if (exp_q.size() == 0) begin
          check("stream_extra_beat", 32'(1), 32'(0));
        end else begin
          b = exp_q.pop_front();
          check("stream_data", m_if.data, b.data);
          check("stream_keep", 32'(m_if.keep), 32'(b.keep));
          check("stream_last", 32'(m_if.last), 32'(b.last));
        end
      end
      if (s_if.valid && s_if.ready) begin
        n_in++;
        acc_data = acc_data | (32'(s_if.data) << (8 * acc_slot));
        acc_keep[acc_slot] = 1'b1;
        acc_slot++;
        if (acc_slot == 4 || s_if.last) begin
          b.data = acc_data;
          b.keep = acc_keep;
          b.last = s_if.last;
          exp_q.push_back(b);
          acc_data = '0;
          acc_keep = '0;
          acc_slot = 0;
        end
      end
    end
  endtask

  task automatic step(input logic sv, input logic [7:0] d, input logic sl, input logic mr);
    @(negedge clk);
    s_if.valid = sv;
    s_if.data  = sv ? d : 8'bx;
    s_if.last  = sl;
    m_if.ready = mr;
    #1;
    observe();
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    check({tag, "_valid"}, 32'(m_if.valid), 32'(1));
    check({tag, "_data"},  m_if.data, d);
    check({tag, "_keep"},  32'(m_if.keep), 32'(k));
    check({tag, "_last"},  32'(m_if.last), 32'(l));
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from clock edges.
  task automatic pulse_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    check({tag, "_m_valid"}, 32'(m_if.valid), 32'(0));
    check({tag, "_m_data"},  m_if.data, 32'(0));
    check({tag, "_m_keep"},  32'(m_if.keep), 32'(0));
    check({tag, "_m_last"},  32'(m_if.last), 32'(0));
    check({tag, "_s_ready"}, 32'(s_if.ready), 32'(1));
    model_clear();
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    s_if.valid = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_in;
    int guard;
    logic sv, sl, mr;
    logic [7:0] d;

    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    s_if.keep  = '1;
    m_if.ready = 1'b0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(m_if.valid), 32'(0));
    check("rst_m_data",  m_if.data, 32'(0));
    check("rst_m_keep",  32'(m_if.keep), 32'(0));
    check("rst_m_last",  32'(m_if.last), 32'(0));
    check("rst_s_ready", 32'(s_if.ready), 32'(1));
    #2;
    rstn = 1'b1;

    // Full group with last on the fourth beat
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("full", 32'h44332211, 4'b1111, 1'b1);
    check("full_s_ready_held", 32'(s_if.ready), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("full_m_valid_clear", 32'(m_if.valid), 32'(0));

    // Short packet, then a single-beat packet from slot 0
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("partial", 32'h0000A2A1, 4'b0011, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hC3, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("single", 32'h000000C3, 4'b0001, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Sustained rate: two groups back to back
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1);
      check("rate_s_ready", 32'(s_if.ready), 32'(1));
      if (i == 5) check_out("rate_g0", 32'h04030201, 4'b1111, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_out("rate_g1", 32'h08070605, 4'b1111, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Output stall with input pushing: nothing accepted, output frozen
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    step(1'b1, 8'h63, 1'b0, 1'b0);
    step(1'b1, 8'h64, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h77, 1'b0, 1'b0);
      check_out("stall", 32'h64636261, 4'b1111, 1'b1);
      check("stall_s_ready", 32'(s_if.ready), 32'(0));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h81, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("after_stall", 32'h00000081, 4'b0001, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset with a stalled output beat held
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b0, 1'b0);
    step(1'b1, 8'hE3, 1'b0, 1'b0);
    step(1'b1, 8'hE4, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("pre_rst", 32'hE4E3E2E1, 4'b1111, 1'b0);
    pulse_reset("rst_stalled");

    // Reset after two of four beats, then a clean group from slot 0
    step(1'b1, 8'h91, 1'b0, 1'b1);
    step(1'b1, 8'h92, 1'b0, 1'b1);
    pulse_reset("rst_partial");
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    step(1'b1, 8'h57, 1'b0, 1'b0);
    step(1'b1, 8'h58, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("post_rst", 32'h58575655, 4'b1111, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Random valid/ready traffic against the packing model
    start_in = n_in;
    guard    = 0;
    while ((n_in - start_in) < 1000 && guard < 30000) begin
      sv = ($urandom_range(0, 4) == 0);
      sl = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 4) == 0);
      d  = 8'($urandom);
      step(sv, d, sl, mr);
      guard++;
    end
    check("rand_budget", 32'(guard < 30000), 32'(1));
    guard = 0;
    start_in = n_in;
    while (n_in == start_in && guard < 50) begin
      step(1'b1, 8'hF0, 1'b1, 1'b1);
      guard++;
    end
    check("rand_close_budget", 32'(guard < 50), 32'(1));
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rand_drain_empty", 32'(exp_q.size()), 32'(0));
    check("rand_no_partial", 32'(acc_slot), 32'(0));
    check("rand_m_valid_idle", 32'(m_if.valid), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_upsize.md
AXIS_UPSIZE -- requirements
Module: axis_upsize

Interface
REQ-001 Parameter WORD_W, default 8, width of one data word in bits.
REQ-002 Parameter S_BUS_W, default 8, input bus width; an integer multiple of WORD_W.
REQ-003 Parameter M_BUS_W, default 32, output bus width; R = M_BUS_W/S_BUS_W is an integer of at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  input beat valid.
REQ-007 s_ready  output  1  input beat accepted this cycle when high together with s_valid.
REQ-008 s_data  input  S_BUS_W  input beat, packed words, word 0 in LSBs.
REQ-009 s_last  input  1  final input beat of a packet.
REQ-010 m_valid  output  1  output beat valid.
REQ-011 m_ready  input  1  downstream accepts when high together with m_valid.
REQ-012 m_data  output  M_BUS_W  packed output beat.
REQ-013 m_keep  output  R  one bit per input-beat slot; high = slot holds real data.
REQ-014 m_last  output  1  final output beat of a packet.

Function
REQ-015 Handshake on either port occurs only at a rising edge where valid and ready are both high.
REQ-016 A slot counter cnt (0..R-1) names the next free slot; accepted input beat k of a group lands in m_data bits [(k+1)*S_BUS_W-1 : k*S_BUS_W].
REQ-017 s_ready = !m_valid || m_ready; combinational from m_ready and registered m_valid only, never from s_valid.
REQ-018 On input handshake with cnt < R-1 and s_last low: word stored in collect buffer slot cnt; cnt increments; outputs unchanged.
REQ-019 On input handshake with cnt == R-1 or s_last high: collect buffer plus current beat transfer to the output register; m_valid set next cycle; m_keep bits 0..cnt set, others clear; m_last = s_last; cnt returns to 0; collect buffer cleared.
REQ-020 Unfilled slots of a partial output beat (s_last early) are driven zero.
REQ-021 Output register (m_data, m_keep, m_last, m_valid) stays stable while m_valid high and m_ready low.
REQ-022 On output handshake with no completing input in the same cycle, m_valid clears next cycle.
REQ-023 Output handshake and completing input handshake in the same cycle: new beat loaded, m_valid stays high; zero bubble at full rate.
REQ-024 Latency: completing input beat at edge N appears as m_valid at edge N (visible after N), one register stage.
REQ-025 Non-completing input beats are accepted while an output beat is stalled only if s_ready is high; s_ready low blocks all input, completing or not.
REQ-026 Sustained throughput with s_valid and m_ready held high: one output beat per R cycles, s_ready never low.
REQ-027 s_data content while s_valid low is ignored and never stored, including X values.

Reset
REQ-028 rstn low asynchronously forces m_valid=0, m_keep=0, m_last=0, m_data=0, cnt=0, collect buffer 0; s_ready therefore 1.
REQ-029 Reset asserted mid-packet discards the partial group and any stalled output beat; first input beat after release goes to slot 0.
REQ-030 No handshake is taken on the rising edge where rstn is low.

Verification (WORD_W=8, S_BUS_W=8, M_BUS_W=32)
REQ-031 Inputs 0x11,0x22,0x33,0x44 (last on 0x44), m_ready=1 -> one beat m_data=0x44332211, m_keep=4'b1111, m_last=1.
REQ-032 Inputs 0xA1,0xA2 with last on 0xA2 -> m_data=0x0000A2A1, m_keep=4'b0011, m_last=1; next packet starts at slot 0.
REQ-033 8 beats 0x01..0x08, s_valid and m_ready high -> 0x04030201 then 0x08070605, s_ready high throughout, no idle cycle between groups.
REQ-034 Full beat waiting with m_ready low 5 cycles -> m_data/m_keep/m_last unchanged, s_ready low, no input accepted until m_ready high.
REQ-035 rstn pulsed low after 2 of 4 beats -> outputs zero immediately; next 4 beats 0x55..0x58 give 0x58575655, m_keep=4'b1111.
REQ-036 Random s_valid (20%) and m_ready (20%), 1000 beats, X on s_data when invalid -> output stream equals packed reference model, no X on m_data when m_valid high.
